// File: rtl/register_bank_pkg.sv
// Shared uDLX register-file definitions: default widths and the hard-wired zero register index.
// Used by register_bank and by the write-back and decode stages that connect to it.
package register_bank_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int NUM_RD_PORTS       = 2;

    localparam logic [DEF_REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage : register_bank_pkg

// File: rtl/register_bank.sv
// uDLX general-purpose register file: R0 reads as zero, one synchronous write port,
// two registered read ports with write-first bypass and a shared stall hold.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0]     wr_data_in,
    input  logic                      rd_hold_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b_in,
    output logic [DATA_WIDTH-1:0]     rd_data_a_out,
    output logic [DATA_WIDTH-1:0]     rd_data_b_out
);

    localparam int DEPTH = 2 ** REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);

    // Flop storage only for R1..R(DEPTH-1); reset clearing rules out a memory macro.
    logic [DATA_WIDTH-1:0] regs_r    [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] regs_view_s [DEPTH];

    // Register array update: clear on reset, otherwise commit the addressed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en_in && (wr_addr_in == REG_ADDR_WIDTH'(i))) begin
                    regs_r[i] <= wr_data_in;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Full-depth read view with index 0 tied to zero rather than stored.
    always_comb begin
        regs_view_s[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_view_s[i] = regs_r[i];
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        logic [REG_ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0]     next_s;
        logic [DATA_WIDTH-1:0]     data_r;

        assign addr_s = (p == 0) ? rd_addr_a_in : rd_addr_b_in;

        // Read select: zero register, then same-edge write bypass, then stored value.
        always_comb begin
            next_s = '0;
            if (addr_s == ZERO_IDX) begin
                next_s = '0;
            end else if (wr_en_in && (wr_addr_in == addr_s)) begin
                next_s = wr_data_in;
            end else begin
                next_s = regs_view_s[addr_s];
            end
        end

        // Read output register; a stall freezes it while writes keep committing.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_r <= '0;
            end else if (!rd_hold_in) begin
                data_r <= next_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign rd_data_a_out = g_rd_port[0].data_r;
    assign rd_data_b_out = g_rd_port[1].data_r;

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural register-file model.
module tb_register_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_en_in;
    logic [4:0]  wr_addr_in;
    logic [31:0] wr_data_in;
    logic        rd_hold_in;
    logic [4:0]  rd_addr_a_in;
    logic [4:0]  rd_addr_b_in;
    logic [31:0] rd_data_a_out;
    logic [31:0] rd_data_b_out;

    int checks = 0;
    int fails  = 0;

    register_bank #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_in     (wr_en_in),
        .wr_addr_in   (wr_addr_in),
        .wr_data_in   (wr_data_in),
        .rd_hold_in   (rd_hold_in),
        .rd_addr_a_in (rd_addr_a_in),
        .rd_addr_b_in (rd_addr_b_in),
        .rd_data_a_out(rd_data_a_out),
        .rd_data_b_out(rd_data_b_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural register contents and the two read outputs.
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_a;
    logic [31:0] mdl_b;

    function automatic logic [31:0] rule_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (wr_en_in && (wr_addr_in == addr)) return wr_data_in;
        return mdl_regs[addr];
    endfunction

    // Model update at each edge; reset clears everything asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mdl_regs[i] <= 32'd0;
            mdl_a <= 32'd0;
            mdl_b <= 32'd0;
        end else begin
            if (wr_en_in && (wr_addr_in != 5'd0)) mdl_regs[wr_addr_in] <= wr_data_in;
            if (!rd_hold_in) begin
                mdl_a <= rule_read(rd_addr_a_in);
                mdl_b <= rule_read(rd_addr_b_in);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cycle_rd_a", rd_data_a_out, mdl_a);
        chk("cycle_rd_b", rd_data_b_out, mdl_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic hold, input logic [4:0] ra, input logic [4:0] rb);
        wr_en_in     = we;
        wr_addr_in   = wa;
        wr_data_in   = wd;
        rd_hold_in   = hold;
        rd_addr_a_in = ra;
        rd_addr_b_in = rb;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        chk("reset_a", rd_data_a_out, 32'd0);
        chk("reset_b", rd_data_b_out, 32'd0);
        rst_n = 1'b1;

        // Preload R5, then assert reset mid-cycle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        tick();
        chk("preload_bypass_r5", rd_data_a_out, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
        tick();
        chk("preload_read_r5", rd_data_b_out, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_a", rd_data_a_out, 32'd0);
        chk("async_reset_b", rd_data_b_out, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        tick();
        chk("r5_after_reset", rd_data_a_out, 32'd0);

        // Basic write then read.
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0);
        tick();
        chk("model_r7", mdl_regs[7], 32'h12345678);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
        tick();
        chk("basic_read_r7", rd_data_a_out, 32'h12345678);

        // R0 protection, both as a later read and as a same-edge bypass attempt.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        tick();
        chk("r0_bypass_a", rd_data_a_out, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        tick();
        chk("r0_read_a", rd_data_a_out, 32'd0);
        chk("r0_read_b", rd_data_b_out, 32'd0);

        // Bypass to both ports, then the same vector without write enable.
        drive(1'b1, 5'd3, 32'h00000001, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd3, 32'hCAFE0003, 1'b0, 5'd3, 5'd3);
        tick();
        chk("bypass_a", rd_data_a_out, 32'hCAFE0003);
        chk("bypass_b", rd_data_b_out, 32'hCAFE0003);
        drive(1'b1, 5'd3, 32'h00000001, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd3, 32'hCAFE0003, 1'b0, 5'd3, 5'd3);
        tick();
        chk("nobypass_a", rd_data_a_out, 32'h00000001);
        chk("nobypass_b", rd_data_b_out, 32'h00000001);

        // Hold freezes outputs while writes still commit.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
        tick();
        chk("hold_pre_r7", rd_data_a_out, 32'h12345678);
        drive(1'b1, 5'd7, 32'h00000000, 1'b1, 5'd3, 5'd0);
        tick();
        chk("hold_keep_a", rd_data_a_out, 32'h12345678);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0);
        tick();
        chk("hold_keep_a2", rd_data_a_out, 32'h12345678);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd7);
        tick();
        chk("release_r3", rd_data_a_out, 32'h00000001);
        chk("release_r7_written", rd_data_b_out, 32'h00000000);

        // A write on the edge during reset is lost.
        drive(1'b1, 5'd9, 32'hAAAA5555, 1'b0, 5'd9, 5'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd3);
        tick();
        chk("reset_write_lost", rd_data_a_out, 32'd0);
        chk("reset_cleared_r3", rd_data_b_out, 32'd0);

        // Random traffic; narrow address range half the time to exercise bypass often.
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] wa, ra, rb;
            if ($urandom_range(0, 1) == 0) begin
                wa = 5'($urandom_range(0, 7));
                ra = 5'($urandom_range(0, 7));
                rb = 5'($urandom_range(0, 7));
            end else begin
                wa = 5'($urandom_range(0, 31));
                ra = 5'($urandom_range(0, 31));
                rb = 5'($urandom_range(0, 31));
            end
            drive(1'($urandom_range(0, 1)), wa, 32'($urandom), ($urandom_range(0, 4) == 0), ra, rb);
            tick();
        end

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_register_bank
